// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Definitions shared by the UART command transmit and receive
//                interfaces: packet layout, frame length and the one-hot
//                encodings of the packet assembly states.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    // Packet layout: byte 0 = {R/W, ADDR[6:0]}, byte 1 = DATA
    localparam int CMD_PKT_LEN   = 16;
    localparam int CMD_RW_BIT    = 15;
    localparam int CMD_ADDR_MSB  = 14;
    localparam int CMD_ADDR_LSB  = 8;
    localparam int CMD_DATA_MSB  = 7;
    localparam int CMD_DATA_LSB  = 0;

    // Start + 8 data + stop
    localparam int UART_FRAME_BITS = 10;

    // One-hot packet assembly states
    localparam logic [1:0] C_ST_WAIT_HI = 2'b01;
    localparam logic [1:0] C_ST_WAIT_LO = 2'b10;

    typedef enum logic [1:0] {
        ST_WAIT_HI = C_ST_WAIT_HI,
        ST_WAIT_LO = C_ST_WAIT_LO
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_out_reg
//  Description : One-entry valid/ready output register for assembled command
//                packets. A new packet is taken when the register is empty or
//                is being drained in the same cycle; otherwise it is dropped
//                and a one-cycle overrun pulse is raised.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                i_load/i_data  - packet completion strobe and packet value
//                i_ready        - consumer ready
//                o_data/o_valid - held packet and its valid flag
//                o_overrun      - 1-cycle pulse: packet dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_accept;

    // Space is available when empty, or when the held packet leaves this cycle
    assign w_accept = !r_valid || i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load && w_accept) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (i_load) begin
                // Held packet is kept untouched; the newcomer is lost
                r_overrun <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_rx_if
//  Description : Rebuilds 16-bit command packets from UART bytes (byte 0 =
//                {R/W, ADDR}, byte 1 = DATA) and presents them on a
//                valid/ready port. Flags inter-byte timeout, framing error
//                and packet overrun with registered one-cycle pulses.
//  Ports       : clk, rst                  - clock, async active-high reset
//                rx_data, rx_done, rx_err  - from the UART byte receiver
//                cmd, cmd_valid, cmd_ready - packet output handshake
//                timeout, frame_err, overrun - status pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_rx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int CMD_PKT_LEN    = 16,
    parameter int BPS            = 115_200,
    parameter int SYS_CLK_FREQ   = 50_000_000,
    parameter int TIMEOUT_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  rx_data,
    input  logic                   rx_done,
    input  logic                   rx_err,
    output logic [CMD_PKT_LEN-1:0] cmd,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   timeout,
    output logic                   frame_err,
    output logic                   overrun
);

    import uart_cmd_pkg::*;

    // Whole-frame gap allowed between byte 0 and byte 1, in clk cycles
    localparam logic [31:0] C_TO_CYCLES =
        32'((SYS_CLK_FREQ / BPS) * UART_FRAME_BITS * TIMEOUT_FRAMES);

    rx_state_t               r_state;
    logic [31:0]             r_cnt;
    logic [DATA_WIDTH-1:0]   r_hi;
    logic                    r_timeout;
    logic                    r_frame_err;

    logic                    w_pkt_done;
    logic [CMD_PKT_LEN-1:0]  w_pkt;

    // Byte 1 completes the packet unless a framing error arrives alongside it
    assign w_pkt_done = (r_state == ST_WAIT_LO) && rx_done && !rx_err;
    assign w_pkt      = {r_hi, rx_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_WAIT_HI;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_timeout   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_timeout   <= 1'b0;
            r_frame_err <= 1'b0;
            if (rx_err) begin
                // Framing error overrides everything and drops any half packet
                r_frame_err <= 1'b1;
                r_hi        <= '0;
                r_cnt       <= '0;
                r_state     <= ST_WAIT_HI;
            end else begin
                case (r_state)
                    ST_WAIT_HI: begin
                        if (rx_done) begin
                            r_hi    <= rx_data;
                            r_cnt   <= '0;
                            r_state <= ST_WAIT_LO;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (rx_done) begin
                            // Late byte on the final count still wins
                            r_cnt   <= '0;
                            r_state <= ST_WAIT_HI;
                        end else if (r_cnt == C_TO_CYCLES - 32'd1) begin
                            r_timeout <= 1'b1;
                            r_hi      <= '0;
                            r_cnt     <= '0;
                            r_state   <= ST_WAIT_HI;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    default: begin
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_HI;
                    end
                endcase
            end
        end
    end

    uart_cmd_out_reg #(
        .WIDTH (CMD_PKT_LEN)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_pkt_done),
        .i_data    (w_pkt),
        .i_ready   (cmd_ready),
        .o_data    (cmd),
        .o_valid   (cmd_valid),
        .o_overrun (overrun)
    );

    assign timeout   = r_timeout;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_rx_if
//  Description : Self-checking bench for uart_cmd_rx_if. Table of simple
//                packets plus hand-written corner sequences; consumed
//                packets are compared against a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx_if;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_err;
    logic [15:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        timeout;
    logic        frame_err;
    logic        overrun;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          gap;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t        vecs [4];
    logic [15:0] exp_q [$];

    int n_pass  = 0;
    int n_total = 0;
    int n_to    = 0;
    int n_fe    = 0;
    int n_ov    = 0;
    int found;

    uart_cmd_rx_if dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .timeout   (timeout),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Caller is at a negedge; byte is captured at the following posedge
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send_err(input logic with_done);
        rx_err  = 1'b1;
        rx_done = with_done;
        @(negedge clk);
        rx_err  = 1'b0;
        rx_done = 1'b0;
    endtask

    // Monitor: samples just before each posedge, counts pulses, scores handshakes
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                if (timeout)   n_to++;
                if (frame_err) n_fe++;
                if (overrun)   n_ov++;
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL sb_unexpected: got cmd 0x%h, expected no packet", cmd);
                    end else begin
                        check("sb_cmd", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{b0: 8'h85, b1: 8'h3C, gap: 100, exp_cmd: 16'h853C};
        vecs[1] = '{b0: 8'h01, b1: 8'h02, gap: 0,   exp_cmd: 16'h0102};
        vecs[2] = '{b0: 8'hFF, b1: 8'h00, gap: 5,   exp_cmd: 16'hFF00};
        vecs[3] = '{b0: 8'h7E, b1: 8'h81, gap: 1,   exp_cmd: 16'h7E81};

        rst = 1'b1; rx_data = '0; rx_done = 1'b0; rx_err = 1'b0; cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {11'h0, cmd, cmd_valid, timeout, frame_err, overrun}, 32'h0);
        rst = 1'b0;
        cmd_ready = 1'b1;
        @(negedge clk);

        // Table of simple packets with the consumer always ready
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].b0);
            repeat (vecs[i].gap) @(negedge clk);
            exp_q.push_back(vecs[i].exp_cmd);
            send_byte(vecs[i].b1);
            check($sformatf("vec%0d_valid", i), {31'h0, cmd_valid}, 32'h1);
            check($sformatf("vec%0d_cmd", i), {16'h0, cmd}, {16'h0, vecs[i].exp_cmd});
            @(negedge clk);
            check($sformatf("vec%0d_valid_clear", i), {31'h0, cmd_valid}, 32'h0);
        end

        // Inter-byte timeout: measured from the byte-0 edge
        send_byte(8'h12);
        found = -1;
        for (int i = 1; i <= 9000; i++) begin
            @(negedge clk);
            if (timeout) begin
                found = i;
                break;
            end
        end
        check("timeout_latency", found, 32'd8680);
        @(negedge clk);
        check("timeout_width", {31'h0, timeout}, 32'h0);
        check("timeout_no_cmd", {31'h0, cmd_valid}, 32'h0);
        exp_q.push_back(16'h0102);
        send_byte(8'h01);
        send_byte(8'h02);
        check("after_timeout_cmd", {16'h0, cmd}, 32'h0102);

        // Byte 1 on the very last count beats the timeout
        send_byte(8'h34);
        repeat (8679) @(negedge clk);
        exp_q.push_back(16'h3456);
        send_byte(8'h56);
        check("edge_byte_valid", {31'h0, cmd_valid}, 32'h1);
        check("edge_byte_no_timeout", {31'h0, timeout}, 32'h0);
        @(negedge clk);

        // Overrun while the output is held
        cmd_ready = 1'b0;
        exp_q.push_back(16'hAA55);
        send_byte(8'hAA);
        send_byte(8'h55);
        check("held_valid", {31'h0, cmd_valid}, 32'h1);
        send_byte(8'h12);
        send_byte(8'h34);
        check("overrun_pulse", {31'h0, overrun}, 32'h1);
        check("held_cmd", {16'h0, cmd}, 32'hAA55);
        @(negedge clk);
        check("overrun_width", {31'h0, overrun}, 32'h0);
        cmd_ready = 1'b1;
        @(negedge clk);
        check("valid_falls", {31'h0, cmd_valid}, 32'h0);

        // Framing error discards the partial packet
        send_byte(8'h80);
        send_err(1'b0);
        check("frame_err_pulse", {31'h0, frame_err}, 32'h1);
        exp_q.push_back(16'h7FFF);
        send_byte(8'h7F);
        send_byte(8'hFF);
        check("after_err_cmd", {16'h0, cmd}, 32'h7FFF);
        @(negedge clk);

        // rx_err beats rx_done in the same cycle
        rx_data = 8'h55;
        send_err(1'b1);
        exp_q.push_back(16'h2233);
        send_byte(8'h22);
        send_byte(8'h33);
        check("err_priority_cmd", {16'h0, cmd}, 32'h2233);
        @(negedge clk);

        // Consume and reload in the same cycle
        cmd_ready = 1'b0;
        exp_q.push_back(16'h4142);
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h43);
        exp_q.push_back(16'h4344);
        cmd_ready = 1'b1;
        send_byte(8'h44);
        check("reload_valid", {31'h0, cmd_valid}, 32'h1);
        check("reload_cmd", {16'h0, cmd}, 32'h4344);
        check("reload_no_overrun", {31'h0, overrun}, 32'h0);
        @(negedge clk);
        check("reload_drained", {31'h0, cmd_valid}, 32'h0);

        // Asynchronous reset with a pending packet and a half packet
        cmd_ready = 1'b0;
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h99);
        #2 rst = 1'b1;
        #1 check("async_rst", {11'h0, cmd, cmd_valid, timeout, frame_err, overrun}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cmd_ready = 1'b1;
        exp_q.push_back(16'h0011);
        send_byte(8'h00);
        send_byte(8'h11);
        check("after_rst_cmd", {16'h0, cmd}, 32'h0011);
        repeat (4) @(negedge clk);

        check("sb_drained", exp_q.size(), 32'd0);
        check("timeout_count", n_to, 32'd1);
        check("frame_err_count", n_fe, 32'd2);
        check("overrun_count", n_ov, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
